// File: rtl/irq_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// irq_arbiter_pkg
// Shared definitions for the interrupt arbiter slice:
//   - N_SRC_DEFAULT : default number of interrupt sources
//   - state_t       : arbiter FSM states (IDLE / REQ / SERVICE)
//   - clog2_id()    : width of a source ID for a given source count
// ---------------------------------------------------------------------------
package irq_arbiter_pkg;

    localparam int N_SRC_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Ceiling log2 for source counts 2..32; never returns less than one bit.
    function automatic int clog2_id(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 6; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// ---------------------------------------------------------------------------
// irq_arbiter_if
// Bundle between the interrupt arbiter and its CPU / interrupt-source side.
//   irq_in  [N_SRC]  raw interrupt lines (synchronous to clk)
//   irq_en  [N_SRC]  per-source enable
//   irq_ack          CPU accepts the presented request (pulse)
//   irq_eoi          CPU end-of-interrupt (pulse)
//   irq_req          request to CPU
//   irq_id  [ID_W]   presented / in-service source ID
//   pending [N_SRC]  pending register readback
// Modports: master = CPU/source side, slave = arbiter.
// ---------------------------------------------------------------------------
interface irq_arbiter_if
    import irq_arbiter_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEFAULT
) ();

    localparam int ID_W = clog2_id(N_SRC);

    logic [N_SRC-1:0] irq_in;
    logic [N_SRC-1:0] irq_en;
    logic             irq_ack;
    logic             irq_eoi;
    logic             irq_req;
    logic [ID_W-1:0]  irq_id;
    logic [N_SRC-1:0] pending;

    modport master (
        output irq_in, irq_en, irq_ack, irq_eoi,
        input  irq_req, irq_id, pending
    );

    modport slave (
        input  irq_in, irq_en, irq_ack, irq_eoi,
        output irq_req, irq_id, pending
    );

endinterface

// File: rtl/irq_arbiter_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
// Combinational lowest-index-first priority encoder.
//   req   [N_SRC]  request vector (bit 0 = highest priority)
//   id    [ID_W]   index of the lowest set bit (0 when none set)
//   valid          at least one request bit is set
// ---------------------------------------------------------------------------
module irq_prio_enc
    import irq_arbiter_pkg::*;
#(
    parameter  int N_SRC = N_SRC_DEFAULT,
    localparam int ID_W  = clog2_id(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        // Scan from the top down so the lowest set index is written last.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// ---------------------------------------------------------------------------
// irq_arbiter
// Interrupt arbiter: captures edge/level interrupt sources into a pending
// register, picks the lowest-index enabled pending source and presents it to
// the CPU through a REQ -> SERVICE handshake (ack, then end-of-interrupt).
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   irq_arbiter_if.slave (irq_in/irq_en/irq_ack/irq_eoi in,
//         irq_req/irq_id/pending out, all outputs registered)
// Parameters: N_SRC (2..32), EDGE_MASK (bit=1 edge-triggered, 0 level).
// ---------------------------------------------------------------------------
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int               N_SRC     = N_SRC_DEFAULT,
    parameter logic [N_SRC-1:0] EDGE_MASK = '1
) (
    input  logic        clk,
    input  logic        rst,
    irq_arbiter_if.slave bus
);

    localparam int ID_W = clog2_id(N_SRC);

    logic [N_SRC-1:0] in_hist;    // irq_in one cycle ago
    logic             armed;      // low for the first cycle after reset
    logic [N_SRC-1:0] edge_q;     // registered rising edges of edge sources
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] set_vec;
    logic [N_SRC-1:0] clr_vec;
    logic [N_SRC-1:0] cand;

    state_t           state, state_n;
    logic [ID_W-1:0]  id_q, id_n;
    logic [ID_W-1:0]  win_id;
    logic             win_valid;
    logic             req_q;

    assign cand = pending_q & bus.irq_en;

    irq_prio_enc #(.N_SRC(N_SRC)) u_enc (
        .req   (cand),
        .id    (win_id),
        .valid (win_valid)
    );

    // Set and clear terms of the pending register; set wins on a collision.
    always_comb begin
        set_vec = edge_q | (bus.irq_in & ~EDGE_MASK);
        clr_vec = '0;
        if (state == ST_REQ && bus.irq_ack) clr_vec[id_q] = 1'b1;
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_hist   <= '0;
            armed     <= 1'b0;
            edge_q    <= '0;
            pending_q <= '0;
        end else begin
            in_hist   <= bus.irq_in;
            armed     <= 1'b1;
            // The history is meaningless on the first post-reset edge, so a
            // line already high through reset release is not seen as an edge.
            edge_q    <= {N_SRC{armed}} & bus.irq_in & ~in_hist & EDGE_MASK;
            pending_q <= (pending_q & ~clr_vec) | set_vec;
        end
    end

    // Next-state logic; the ID is only re-arbitrated when leaving IDLE.
    always_comb begin
        state_n = state;
        id_n    = id_q;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    state_n = ST_REQ;
                    id_n    = win_id;
                end
            end
            ST_REQ: begin
                // Ack has priority over a simultaneous eoi or withdraw.
                if (bus.irq_ack)     state_n = ST_SERVICE;
                else if (!cand[id_q]) state_n = ST_IDLE;
            end
            ST_SERVICE: begin
                if (bus.irq_eoi) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            id_q  <= '0;
            req_q <= 1'b0;
        end else begin
            state <= state_n;
            id_q  <= id_n;
            req_q <= (state_n == ST_REQ);
        end
    end

    assign bus.irq_req = req_q;
    assign bus.irq_id  = id_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_irq_arbiter
// Self-checking bench for irq_arbiter (8 sources, source 0 level-triggered,
// sources 1..7 edge-triggered). Directed scenario tasks plus a randomized
// run compared cycle by cycle against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_irq_arbiter;
    import irq_arbiter_pkg::*;

    localparam int           N     = 8;
    localparam logic [N-1:0] EMASK = 8'hFE;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    irq_arbiter_if #(.N_SRC(N)) bus ();

    irq_arbiter #(.N_SRC(N), .EDGE_MASK(EMASK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: pending set, whether a request is presented or in
    // service, and the last two irq_in samples with their reset status.
    logic [N-1:0] m_pending = '0;
    bit           m_pres    = 1'b0;
    bit           m_serv    = 1'b0;
    int           m_id      = 0;
    logic [N-1:0] in_d1 = '0, in_d2 = '0;
    bit           ok_d1 = 1'b0, ok_d2 = 1'b0;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Applies the arbiter rules to the inputs seen at this clock edge.
    task automatic model_edge();
        logic [N-1:0] cand, setv, clrv;
        if (rst) begin
            m_pending = '0;
            m_pres    = 1'b0;
            m_serv    = 1'b0;
            m_id      = 0;
        end else begin
            cand = m_pending & bus.irq_en;
            // An edge source pends two edges after its 0->1 transition, and
            // only if neither of the two preceding edges was a reset edge.
            setv = ((ok_d1 && ok_d2) ? (in_d1 & ~in_d2 & EMASK) : '0)
                 | (bus.irq_in & ~EMASK);
            clrv = '0;
            if (m_pres && bus.irq_ack) clrv[m_id] = 1'b1;
            if (m_pres) begin
                if (bus.irq_ack) begin
                    m_pres = 1'b0;
                    m_serv = 1'b1;
                end else if (!cand[m_id]) begin
                    m_pres = 1'b0;
                end
            end else if (m_serv) begin
                if (bus.irq_eoi) m_serv = 1'b0;
            end else if (cand != '0) begin
                m_pres = 1'b1;
                m_id   = lowest(cand);
            end
            m_pending = (m_pending & ~clrv) | setv;
        end
        in_d2 = in_d1;
        in_d1 = bus.irq_in;
        ok_d2 = ok_d1;
        ok_d1 = !rst;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.irq_in  = '0;
        bus.irq_en  = '1;
        bus.irq_ack = 1'b0;
        bus.irq_eoi = 1'b0;
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    task automatic ack_eoi();
        bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
        bus.irq_eoi = 1'b1; step(1); bus.irq_eoi = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (bus.irq_req !== 1'b0 || bus.irq_id !== 3'd0 || bus.pending !== 8'h00) begin
            fails++;
            $display("FAIL reset: req=%b id=%0d pending=%h, want 0/0/00",
                     bus.irq_req, bus.irq_id, bus.pending);
        end
    endtask

    task automatic test_edge_latency();
        do_reset();
        bus.irq_in[5] = 1'b1; step(1);
        bus.irq_in[5] = 1'b0; step(1);
        tests++;
        if (bus.irq_req !== 1'b0 || bus.pending !== 8'h20) begin
            fails++;
            $display("FAIL edge_pend: req=%b pending=%h, want 0/20", bus.irq_req, bus.pending);
        end
        step(1);
        tests++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd5) begin
            fails++;
            $display("FAIL edge_latency: req=%b id=%0d, want 1/5", bus.irq_req, bus.irq_id);
        end
        bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
        tests++;
        if (bus.pending[5] !== 1'b0 || dut.state !== ST_SERVICE || bus.irq_req !== 1'b0
            || bus.irq_id !== 3'd5) begin
            fails++;
            $display("FAIL edge_ack: pending=%h state=%0d req=%b id=%0d, want 00/SERVICE/0/5",
                     bus.pending, dut.state, bus.irq_req, bus.irq_id);
        end
        bus.irq_eoi = 1'b1; step(1); bus.irq_eoi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bus.irq_req !== 1'b0) begin
                fails++;
                $display("FAIL edge_after_eoi: cycle %0d req=%b, want 0", i, bus.irq_req);
            end
            step(1);
        end
    endtask

    task automatic test_priority();
        do_reset();
        bus.irq_in = 8'h44; step(1);
        bus.irq_in = 8'h00; step(2);
        tests++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd2) begin
            fails++;
            $display("FAIL prio_first: req=%b id=%0d, want 1/2", bus.irq_req, bus.irq_id);
        end
        ack_eoi();
        tests++;
        if (bus.irq_req !== 1'b0) begin
            fails++;
            $display("FAIL prio_gap: req=%b, want 0", bus.irq_req);
        end
        step(1);
        tests++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd6) begin
            fails++;
            $display("FAIL prio_second: req=%b id=%0d, want 1/6", bus.irq_req, bus.irq_id);
        end
        ack_eoi();
    endtask

    task automatic test_no_preempt();
        do_reset();
        bus.irq_in[4] = 1'b1; step(1);
        bus.irq_in[4] = 1'b0; step(2);
        bus.irq_in[1] = 1'b1; step(1);
        bus.irq_in[1] = 1'b0; step(3);
        tests++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd4 || bus.pending[1] !== 1'b1) begin
            fails++;
            $display("FAIL no_preempt: req=%b id=%0d pending=%h, want 1/4/pending[1]=1",
                     bus.irq_req, bus.irq_id, bus.pending);
        end
        ack_eoi();
        step(1);
        tests++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd1) begin
            fails++;
            $display("FAIL after_preempt: req=%b id=%0d, want 1/1", bus.irq_req, bus.irq_id);
        end
        ack_eoi();
    endtask

    task automatic test_enable_withdraw();
        do_reset();
        bus.irq_en = 8'hF7;
        bus.irq_in[3] = 1'b1; step(1);
        bus.irq_in[3] = 1'b0; step(4);
        tests++;
        if (bus.pending[3] !== 1'b1 || bus.irq_req !== 1'b0) begin
            fails++;
            $display("FAIL en_blocked: pending=%h req=%b, want pending[3]=1 req=0",
                     bus.pending, bus.irq_req);
        end
        bus.irq_en = 8'hFF; step(1);
        tests++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd3) begin
            fails++;
            $display("FAIL en_request: req=%b id=%0d, want 1/3", bus.irq_req, bus.irq_id);
        end
        bus.irq_en = 8'hF7; step(1);
        tests++;
        if (bus.irq_req !== 1'b0 || dut.state !== ST_IDLE || bus.pending[3] !== 1'b1) begin
            fails++;
            $display("FAIL withdraw: req=%b state=%0d pending=%h, want 0/IDLE/pending[3]=1",
                     bus.irq_req, dut.state, bus.pending);
        end
        bus.irq_en = 8'hFF; step(1);
        ack_eoi();
    endtask

    task automatic test_level_and_collision();
        do_reset();
        bus.irq_in[0] = 1'b1; step(2);
        tests++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd0) begin
            fails++;
            $display("FAIL level_req: req=%b id=%0d, want 1/0", bus.irq_req, bus.irq_id);
        end
        bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
        tests++;
        if (bus.pending[0] !== 1'b1 || dut.state !== ST_SERVICE) begin
            fails++;
            $display("FAIL level_repend: pending=%h state=%0d, want pending[0]=1 SERVICE",
                     bus.pending, dut.state);
        end
        bus.irq_eoi = 1'b1; step(1); bus.irq_eoi = 1'b0;
        step(1);
        tests++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd0) begin
            fails++;
            $display("FAIL level_rereq: req=%b id=%0d, want 1/0", bus.irq_req, bus.irq_id);
        end
        bus.irq_in[0] = 1'b0;
        ack_eoi();
        step(1);
        // Second rising edge on source 7 lands its set on the ack edge of id 7.
        bus.irq_in[7] = 1'b1; step(1);
        bus.irq_in[7] = 1'b0; step(1);
        bus.irq_in[7] = 1'b1; step(1);
        tests++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd7) begin
            fails++;
            $display("FAIL coll_req: req=%b id=%0d, want 1/7", bus.irq_req, bus.irq_id);
        end
        bus.irq_in[7] = 1'b0;
        bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
        tests++;
        if (bus.pending[7] !== 1'b1) begin
            fails++;
            $display("FAIL set_wins: pending=%h, want pending[7]=1", bus.pending);
        end
        bus.irq_eoi = 1'b1; step(1); bus.irq_eoi = 1'b0;
        step(1);
        tests++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd7) begin
            fails++;
            $display("FAIL coll_rereq: req=%b id=%0d, want 1/7", bus.irq_req, bus.irq_id);
        end
        ack_eoi();
    endtask

    task automatic test_reset_in_service();
        do_reset();
        bus.irq_in[2] = 1'b1; step(3);
        bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
        tests++;
        if (dut.state !== ST_SERVICE || bus.irq_id !== 3'd2) begin
            fails++;
            $display("FAIL svc_setup: state=%0d id=%0d, want SERVICE/2", dut.state, bus.irq_id);
        end
        rst = 1'b1; step(1);
        tests++;
        if (bus.irq_req !== 1'b0 || bus.irq_id !== 3'd0 || bus.pending !== 8'h00) begin
            fails++;
            $display("FAIL svc_reset: req=%b id=%0d pending=%h, want 0/0/00",
                     bus.irq_req, bus.irq_id, bus.pending);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            tests++;
            if (bus.irq_req !== 1'b0 || bus.pending !== 8'h00) begin
                fails++;
                $display("FAIL held_through_reset: cycle %0d req=%b pending=%h, want 0/00",
                         i, bus.irq_req, bus.pending);
            end
        end
        bus.irq_in[2] = 1'b0; step(1);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            bus.irq_in  = N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) bus.irq_en = N'($urandom | $urandom);
            bus.irq_ack = ($urandom_range(0, 2) == 0);
            bus.irq_eoi = ($urandom_range(0, 2) == 0);
            step(1);
            tests++;
            if (bus.irq_req !== m_pres || bus.irq_id !== 3'(m_id) || bus.pending !== m_pending) begin
                fails++;
                $display("FAIL random c=%0d: req=%b id=%0d pending=%h, want %b/%0d/%h",
                         c, bus.irq_req, bus.irq_id, bus.pending, m_pres, m_id, m_pending);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_edge_latency();
        test_priority();
        test_no_preempt();
        test_enable_withdraw();
        test_level_and_collision();
        test_reset_in_service();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
